// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline execute stage.
// Contents:
//   - ALU operation codes driven on ALUOp by the decode stage
//   - ex_stage FSM state encoding
//   - EX/MEM control-bit bundle and its bubble value
//   - fwd_hit(): register-match test used by the forwarding muxes
package mips_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_LUI  = 5'd11;
    localparam logic [4:0] ALU_DIVU = 5'd12;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDiv  = 2'd1,
        StDone = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } exmem_ctrl_t;

    localparam exmem_ctrl_t CtrlBubble = '0;

    // True when a writer to wr_reg should supply the operand read from src.
    // r0 is hard-wired to zero and never forwards.
    function automatic logic fwd_hit(input logic we, input logic [4:0] wr_reg,
                                     input logic [4:0] src);
        return we && (wr_reg != 5'd0) && (wr_reg == src);
    endfunction

endpackage

// File: rtl/divu_iter.sv
// Iterative unsigned divider: restoring algorithm, one quotient bit per cycle,
// W steps per division. A zero divisor yields an all-ones quotient.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        latch a_i / b_i and begin a division
//   abort_i        drop any division in progress (wins over start_i)
//   a_i, b_i       dividend, divisor
//   busy_o         division in progress
//   done_o         high during the cycle that performs the final step
//   quotient_o     result, valid from the cycle after done_o
module divu_iter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);

    localparam int unsigned CntW = $clog2(W);

    logic            busy_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    dvs_q;
    logic            bzero_q;

    logic [W:0]      rem_sh;
    logic [W:0]      diff;
    logic [W-1:0]    rem_d;
    logic [W-1:0]    quo_d;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract; bit W of the difference is the borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (diff[W]) begin
            rem_d = rem_sh[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
        end else begin
            rem_d = diff[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
        end
    end

    assign done_o     = busy_q && (cnt_q == CntW'(W - 1));
    assign busy_o     = busy_q;
    assign quotient_o = bzero_q ? '1 : quo_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            bzero_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_i;
            dvs_q   <= b_i;
            bzero_q <= (b_i == '0);
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Forwards rs/rt from EX/MEM and MEM/WB, computes the ALU result and owns the
// EX/MEM pipeline register. DIVU runs on divu_iter; stall_out holds upstream
// stages while the divide is in flight.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   *_in (ID/EX)              control bits, ALU op, operands, register indices
//   MEMWB_*                   writeback-stage forwarding source
//   flush                     squash the instruction in EX
//   stall_out                 hold PC, IF/ID and ID/EX
//   *_out (EX/MEM)            registered control, result, zero flag, store data,
//                             destination register
module ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned FWD_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RegDst_in,
    input  logic         ALUSrc_in,
    input  logic         Branch_in,
    input  logic         MemRead_in,
    input  logic         MemWrite_in,
    input  logic         RegWrite_in,
    input  logic [4:0]   ALUOp_in,
    input  logic [W-1:0] Reg1_in,
    input  logic [W-1:0] Reg2_in,
    input  logic [W-1:0] Ext_in,
    input  logic [4:0]   Rs_in,
    input  logic [4:0]   Rt_in,
    input  logic [4:0]   Rd_in,
    input  logic [4:0]   shamt_in,
    input  logic         MEMWB_RegWrite,
    input  logic [4:0]   MEMWB_WrReg,
    input  logic [W-1:0] MEMWB_Data,
    input  logic         flush,
    output logic         stall_out,
    output logic         Branch_out,
    output logic         MemRead_out,
    output logic         MemWrite_out,
    output logic         RegWrite_out,
    output logic [W-1:0] ALURes_out,
    output logic         Zero_out,
    output logic [W-1:0] WrData_out,
    output logic [4:0]   WrReg_out
);

    ex_state_e    state_q, state_d;

    exmem_ctrl_t  ctrl_in;
    exmem_ctrl_t  ctrl_q, ctrl_d;
    logic [W-1:0] res_q, res_d;
    logic         zero_q, zero_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic [4:0]   wreg_q, wreg_d;

    // Control, store data and destination of the DIVU in flight.
    exmem_ctrl_t  held_ctrl_q;
    logic [W-1:0] held_wdata_q;
    logic [4:0]   held_wreg_q;

    logic [W-1:0] fwd_a, fwd_b, op_b, alu_res;
    logic [4:0]   wr_reg;
    logic         stall;
    logic         div_start, div_abort, div_busy, div_done;
    logic [W-1:0] div_quot;

    assign ctrl_in = '{branch:    Branch_in,
                       mem_read:  MemRead_in,
                       mem_write: MemWrite_in,
                       reg_write: RegWrite_in};

    // ---------------------------------------------------------------------
    // Forwarding. A load in EX/MEM has no data yet, so it never forwards.
    // ---------------------------------------------------------------------
    always_comb begin
        fwd_a = Reg1_in;
        fwd_b = Reg2_in;
        if (FWD_EN != 0) begin
            if (fwd_hit(ctrl_q.reg_write && !ctrl_q.mem_read, wreg_q, Rs_in)) begin
                fwd_a = res_q;
            end else if (fwd_hit(MEMWB_RegWrite, MEMWB_WrReg, Rs_in)) begin
                fwd_a = MEMWB_Data;
            end
            if (fwd_hit(ctrl_q.reg_write && !ctrl_q.mem_read, wreg_q, Rt_in)) begin
                fwd_b = res_q;
            end else if (fwd_hit(MEMWB_RegWrite, MEMWB_WrReg, Rt_in)) begin
                fwd_b = MEMWB_Data;
            end
        end
    end

    assign op_b   = ALUSrc_in ? Ext_in : fwd_b;
    assign wr_reg = RegDst_in ? Rd_in : Rt_in;

    // ---------------------------------------------------------------------
    // Single-cycle ALU. DIVU is handled by the divider, not here.
    // ---------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (ALUOp_in)
            ALU_ADD:  alu_res = fwd_a + op_b;
            ALU_SUB:  alu_res = fwd_a - op_b;
            ALU_AND:  alu_res = fwd_a & op_b;
            ALU_OR:   alu_res = fwd_a | op_b;
            ALU_XOR:  alu_res = fwd_a ^ op_b;
            ALU_NOR:  alu_res = ~(fwd_a | op_b);
            ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(W-1){1'b0}}, (fwd_a < op_b)};
            ALU_SLL:  alu_res = fwd_b << shamt_in;
            ALU_SRL:  alu_res = fwd_b >> shamt_in;
            ALU_SRA:  alu_res = $signed(fwd_b) >>> shamt_in;
            ALU_LUI:  alu_res = Ext_in << 16;
            default:  alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM next-state and EX/MEM next value. Bubble is the default capture.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        ctrl_d    = CtrlBubble;
        res_d     = '0;
        zero_d    = 1'b0;
        wdata_d   = '0;
        wreg_d    = '0;

        if (flush) begin
            state_d   = StIdle;
            div_abort = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ALUOp_in == ALU_DIVU) begin
                        stall     = 1'b1;
                        div_start = 1'b1;
                        state_d   = StDiv;
                    end else begin
                        ctrl_d  = ctrl_in;
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        wdata_d = fwd_b;
                        wreg_d  = wr_reg;
                    end
                end
                StDiv: begin
                    stall = 1'b1;
                    if (div_done) begin
                        state_d = StDone;
                    end else if (!div_busy) begin
                        // Unreachable in normal operation; recover rather than hang.
                        state_d = StIdle;
                    end
                end
                StDone: begin
                    ctrl_d  = held_ctrl_q;
                    res_d   = div_quot;
                    zero_d  = (div_quot == '0);
                    wdata_d = held_wdata_q;
                    wreg_d  = held_wreg_q;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Gated with rst so stall drops the moment reset asserts, even if
    // ID/EX still presents a DIVU.
    assign stall_out = stall & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            ctrl_q       <= CtrlBubble;
            res_q        <= '0;
            zero_q       <= 1'b0;
            wdata_q      <= '0;
            wreg_q       <= '0;
            held_ctrl_q  <= CtrlBubble;
            held_wdata_q <= '0;
            held_wreg_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
            if (div_start) begin
                held_ctrl_q  <= ctrl_in;
                held_wdata_q <= fwd_b;
                held_wreg_q  <= wr_reg;
            end
        end
    end

    divu_iter #(
        .W (W)
    ) u_divu (
        .clk_i      (clk),
        .rst_ni     (rst),
        .start_i    (div_start),
        .abort_i    (div_abort),
        .a_i        (fwd_a),
        .b_i        (op_b),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign Branch_out   = ctrl_q.branch;
    assign MemRead_out  = ctrl_q.mem_read;
    assign MemWrite_out = ctrl_q.mem_write;
    assign RegWrite_out = ctrl_q.reg_write;
    assign ALURes_out   = res_q;
    assign Zero_out     = zero_q;
    assign WrData_out   = wdata_q;
    assign WrReg_out    = wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver computes each cycle's expected
// stall and EX/MEM contents from a behavioural model and queues them; the
// monitor samples the DUT and compares.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegDst_in, ALUSrc_in, Branch_in, MemRead_in, MemWrite_in, RegWrite_in;
    logic [4:0]  ALUOp_in;
    logic [31:0] Reg1_in, Reg2_in, Ext_in;
    logic [4:0]  Rs_in, Rt_in, Rd_in, shamt_in;
    logic        MEMWB_RegWrite;
    logic [4:0]  MEMWB_WrReg;
    logic [31:0] MEMWB_Data;
    logic        flush;
    logic        stall_out, Branch_out, MemRead_out, MemWrite_out, RegWrite_out, Zero_out;
    logic [31:0] ALURes_out, WrData_out;
    logic [4:0]  WrReg_out;

    ex_stage #(.W(32), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst),
        .RegDst_in(RegDst_in), .ALUSrc_in(ALUSrc_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .ALUOp_in(ALUOp_in), .Reg1_in(Reg1_in), .Reg2_in(Reg2_in), .Ext_in(Ext_in),
        .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .shamt_in(shamt_in),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_WrReg(MEMWB_WrReg), .MEMWB_Data(MEMWB_Data),
        .flush(flush), .stall_out(stall_out),
        .Branch_out(Branch_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .RegWrite_out(RegWrite_out), .ALURes_out(ALURes_out), .Zero_out(Zero_out),
        .WrData_out(WrData_out), .WrReg_out(WrReg_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        regdst, alusrc, branch, memread, memwrite, regwrite;
        logic [4:0]  op;
        logic [31:0] r1, r2, ext;
        logic [4:0]  rs, rt, rd, shamt;
    } instr_t;

    typedef struct packed {
        logic        stall;
        logic [3:0]  ctrl;   // {branch, memread, memwrite, regwrite}
        logic [31:0] res;
        logic        zero;
        logic [31:0] wdata;
        logic [4:0]  wreg;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        prev;       // model's view of EX/MEM contents
    exp_t        div_out;    // what a pending DIVU will write
    int          div_left;   // cycles left in a pending DIVU, DONE cycle included
    logic        wb_rw;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regv);
        if (prev.ctrl[0] && !prev.ctrl[2] && prev.wreg != 5'd0 && prev.wreg == r)
            return prev.res;
        if (wb_rw && wb_reg != 5'd0 && wb_reg == r)
            return wb_data;
        return regv;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] ob, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [31:0] ext);
        case (op)
            5'd0:  return a + ob;
            5'd1:  return a - ob;
            5'd2:  return a & ob;
            5'd3:  return a | ob;
            5'd4:  return a ^ ob;
            5'd5:  return ~(a | ob);
            5'd6:  return ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
            5'd7:  return (a < ob) ? 32'd1 : 32'd0;
            5'd8:  return b << sh;
            5'd9:  return b >> sh;
            5'd10: return 32'($signed(b) >>> sh);
            5'd11: return {ext[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    // One clock of stimulus: apply inputs, model the outcome, queue it.
    task automatic drive_cycle(input instr_t in, input logic fl, output logic st);
        exp_t        e;
        logic [31:0] a, b, ob;
        @(negedge clk);
        RegDst_in = in.regdst; ALUSrc_in = in.alusrc; Branch_in = in.branch;
        MemRead_in = in.memread; MemWrite_in = in.memwrite; RegWrite_in = in.regwrite;
        ALUOp_in = in.op; Reg1_in = in.r1; Reg2_in = in.r2; Ext_in = in.ext;
        Rs_in = in.rs; Rt_in = in.rt; Rd_in = in.rd; shamt_in = in.shamt;
        MEMWB_RegWrite = wb_rw; MEMWB_WrReg = wb_reg; MEMWB_Data = wb_data;
        flush = fl;
        a  = fwd(in.rs, in.r1);
        b  = fwd(in.rt, in.r2);
        ob = in.alusrc ? in.ext : b;
        e  = '0;
        if (div_left > 0) begin
            if (fl) div_left = 0;
            else if (div_left > 1) begin e.stall = 1'b1; div_left--; end
            else begin e = div_out; div_left = 0; end
        end else if (!fl) begin
            if (in.op == 5'd12) begin
                e.stall        = 1'b1;
                div_left       = 33;
                div_out        = '0;
                div_out.ctrl   = {in.branch, in.memread, in.memwrite, in.regwrite};
                div_out.res    = (ob == 32'd0) ? 32'hFFFF_FFFF : a / ob;
                div_out.zero   = (div_out.res == 32'd0);
                div_out.wdata  = b;
                div_out.wreg   = in.regdst ? in.rd : in.rt;
            end else begin
                e.ctrl  = {in.branch, in.memread, in.memwrite, in.regwrite};
                e.res   = alu_ref(in.op, a, ob, b, in.shamt, in.ext);
                e.zero  = (e.res == 32'd0);
                e.wdata = b;
                e.wreg  = in.regdst ? in.rd : in.rt;
            end
        end
        exp_q.push_back(e);
        prev = e;
        st   = e.stall;
    endtask

    task automatic rand_wb();
        wb_rw   = 1'($urandom);
        wb_reg  = 5'($urandom_range(0, 3));
        wb_data = $urandom;
    endtask

    // Issue one instruction, holding it while the model says upstream stalls.
    task automatic run_instr(input instr_t in, input int flush_at, input bit rnd);
        logic st;
        int   k = 0;
        do begin
            if (rnd) rand_wb();
            drive_cycle(in, k == flush_at, st);
            k++;
        end while (st);
    endtask

    task automatic kat(input string name, input logic [31:0] act_dummy_unused,
                       input logic [31:0] want);
        @(posedge clk);
        #1;
        chk(name, ALURes_out, want);
    endtask

    function automatic instr_t mk(input logic [4:0] op, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd);
        instr_t i = '0;
        i.op = op; i.r1 = r1; i.r2 = r2; i.rs = rs; i.rt = rt; i.rd = rd;
        i.regdst = 1'b1; i.regwrite = 1'b1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.regdst   = 1'($urandom);
        i.alusrc   = 1'($urandom);
        i.branch   = 1'($urandom);
        i.memread  = ($urandom_range(0, 3) == 0);
        i.memwrite = 1'($urandom);
        i.regwrite = 1'($urandom);
        i.op       = 5'($urandom_range(0, 15));
        if (i.op == 5'd12 && $urandom_range(0, 3) != 0) i.op = 5'($urandom_range(0, 11));
        i.r1       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
        i.r2       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        i.ext      = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
        i.rs       = 5'($urandom_range(0, 3));
        i.rt       = 5'($urandom_range(0, 3));
        i.rd       = 5'($urandom_range(0, 3));
        i.shamt    = 5'($urandom);
        return i;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        logic st;
        forever begin
            @(negedge clk);
            #2;
            st = stall_out;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_out", 32'(st), 32'(e.stall));
                chk("ctrl", 32'({Branch_out, MemRead_out, MemWrite_out, RegWrite_out}),
                    32'(e.ctrl));
                chk("ALURes_out", ALURes_out, e.res);
                chk("Zero_out", 32'(Zero_out), 32'(e.zero));
                chk("WrData_out", WrData_out, e.wdata);
                chk("WrReg_out", 32'(WrReg_out), 32'(e.wreg));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    initial begin : driver
        instr_t i;
        logic   st;
        int     fa;
        RegDst_in = 0; ALUSrc_in = 0; Branch_in = 0; MemRead_in = 0; MemWrite_in = 0;
        RegWrite_in = 0; ALUOp_in = 0; Reg1_in = 0; Reg2_in = 0; Ext_in = 0;
        Rs_in = 0; Rt_in = 0; Rd_in = 0; shamt_in = 0;
        MEMWB_RegWrite = 0; MEMWB_WrReg = 0; MEMWB_Data = 0; flush = 0;
        wb_rw = 0; wb_reg = 0; wb_data = 0;
        prev = '0; div_out = '0; div_left = 0;

        #12;
        chk("reset_res", ALURes_out, 32'd0);
        chk("reset_ctrl", 32'({Branch_out, MemRead_out, MemWrite_out, RegWrite_out}), 32'd0);
        chk("reset_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // ADD 5+7 -> r3
        run_instr(mk(5'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3), -1, 0);
        kat("add_5_7", 32'd0, 32'd12);
        chk("add_wrreg", 32'(WrReg_out), 32'd3);

        // r3 = 1+2, then r4 = r3 - r3 with stale operands: EX/MEM forward
        run_instr(mk(5'd0, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3), -1, 0);
        run_instr(mk(5'd1, 32'd0, 32'd0, 5'd3, 5'd3, 5'd4), -1, 0);
        @(posedge clk); #1;
        chk("sub_fwd_zero", 32'(Zero_out), 32'd1);

        // EX/MEM writes r5; MEM/WB has r3=9
        run_instr(mk(5'd0, 32'd4, 32'd4, 5'd1, 5'd2, 5'd5), -1, 0);
        wb_rw = 1; wb_reg = 5'd3; wb_data = 32'd9;
        run_instr(mk(5'd0, 32'd0, 32'd0, 5'd3, 5'd0, 5'd6), -1, 0);
        kat("memwb_fwd", 32'd0, 32'd9);

        // r0 match never forwards
        wb_rw = 1; wb_reg = 5'd0; wb_data = 32'd77;
        run_instr(mk(5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7), -1, 0);
        kat("r0_nofwd", 32'd0, 32'd0);
        wb_rw = 0;

        // DIVU 100/7 and 5/0, back to back
        run_instr(mk(5'd12, 32'd100, 32'd7, 5'd10, 5'd11, 5'd12), -1, 0);
        kat("divu_100_7", 32'd0, 32'd14);
        run_instr(mk(5'd12, 32'd5, 32'd0, 5'd10, 5'd11, 5'd12), -1, 0);
        kat("divu_by0", 32'd0, 32'hFFFF_FFFF);
        run_instr(mk(5'd12, 32'd1000, 32'd10, 5'd10, 5'd11, 5'd13), -1, 0);
        run_instr(mk(5'd12, 32'd77, 32'd7, 5'd10, 5'd11, 5'd14), -1, 0);

        // Flush at DIV cycle 10, then an ADD
        run_instr(mk(5'd12, 32'd100, 32'd7, 5'd10, 5'd11, 5'd12), 10, 0);
        run_instr(mk(5'd0, 32'd20, 32'd22, 5'd10, 5'd11, 5'd15), -1, 0);
        kat("add_after_flush", 32'd0, 32'd42);

        // Reset at DIV cycle 20
        i = mk(5'd12, 32'd100, 32'd7, 5'd10, 5'd11, 5'd12);
        for (int k = 0; k <= 20; k++) drive_cycle(i, 1'b0, st);
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_mid_res", ALURes_out, 32'd0);
        chk("rst_mid_ctrl", 32'({Branch_out, MemRead_out, MemWrite_out, RegWrite_out}),
            32'd0);
        chk("rst_mid_wrreg", 32'(WrReg_out), 32'd0);
        chk("rst_mid_stall", 32'(stall_out), 32'd0);
        prev = '0; div_left = 0;
        ALUOp_in = 5'd0; RegWrite_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_instr(mk(5'd0, 32'd1, 32'd1, 5'd10, 5'd11, 5'd8), -1, 0);
        kat("add_after_reset", 32'd0, 32'd2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            i  = rand_instr();
            fa = -1;
            if ($urandom_range(0, 15) == 0) fa = 0;
            else if (i.op == 5'd12 && $urandom_range(0, 2) == 0) fa = $urandom_range(1, 34);
            run_instr(i, fa, 1);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
